vend_controller: RTL and testbench
==================================

VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024, idle cycles allowed in COLLECT before automatic refund (valid only when VEND_TIMEOUT_EN is defined).
REQ-002 clk  input  1  system clock, all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 sel_rdy  input  1  selection-ready flag from the button scanner.
REQ-005 sel_data  input  8  serial selection bus: fee, then station code.
REQ-006 sel_cmp  input  1  selection-complete pulse from the button scanner.
REQ-007 coin_valid  input  1  one-cycle strobe, coin accepted by mechanism.
REQ-008 coin_val  input  8  coin value, qualified by coin_valid.
REQ-009 cancel  input  1  passenger cancel request, level.
REQ-010 ticket_go  output  1  one-cycle ticket print strobe.
REQ-011 ticket_stn  output  8  station code, valid with ticket_go.
REQ-012 change_go  output  1  one-cycle change/refund strobe.
REQ-013 change_amt  output  8  amount to return, valid with change_go.
REQ-014 credit  output  8  current inserted credit.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err  output  1  one-cycle strobe on protocol or fee error.
REQ-017 coin_rej  output  1  one-cycle strobe, coin arrived outside COLLECT.

Function
REQ-018 States SHALL be IDLE, FEE, STN, SYNC, COLLECT, DISPENSE, CHANGE, REFUND; all outputs registered.
REQ-019 IDLE: sel_rdy=1 -> FEE next cycle.
REQ-020 FEE: sel_data captured as fee, -> STN; STN: sel_data captured as station, -> SYNC.
REQ-021 SYNC: sel_cmp=1 -> COLLECT; sel_rdy=0 and sel_cmp=0 -> err pulse, -> IDLE.
REQ-022 Captured fee of 0 SHALL produce err pulse on SYNC exit and return to IDLE instead of COLLECT.
REQ-023 COLLECT: coin_valid adds coin_val to credit, saturating at 255; no wrap.
REQ-024 COLLECT: when updated credit >= fee -> DISPENSE next cycle.
REQ-025 DISPENSE: ticket_go=1 for exactly one cycle, ticket_stn=station; then -> CHANGE if credit>fee, else IDLE with credit cleared.
REQ-026 CHANGE: change_go=1 one cycle, change_amt=credit-fee (8-bit, never negative); credit cleared; -> IDLE.
REQ-027 COLLECT with cancel=1 -> REFUND; REFUND: if credit>0, change_go=1 with change_amt=credit; credit cleared; -> IDLE.
REQ-028 Coin and cancel in same cycle: coin added first; cancel wins even if credit reaches fee; refund includes that coin.
REQ-029 coin_valid in any state other than COLLECT: credit unchanged, coin_rej=1 next cycle.
REQ-030 sel_rdy outside IDLE SHALL be ignored; cancel outside COLLECT SHALL be ignored.
REQ-031 ticket_go and change_go SHALL never be high in the same cycle.
REQ-032 ticket_stn and change_amt SHALL hold last value when their strobe is low.

Reset
REQ-033 rst=1 SHALL force IDLE and clear all outputs, fee, station, credit and timeout counter to 0 immediately.
REQ-034 Reset mid-transaction SHALL discard credit with no refund strobe.

Configuration
REQ-035 Macro VEND_TIMEOUT_EN defined: counter clears on COLLECT entry and on each coin, increments each other COLLECT cycle; reaching TIMEOUT_CYCLES-1 -> REFUND.
REQ-036 Macro VEND_TIMEOUT_EN undefined: no counter; COLLECT exits only via payment or cancel.

Verification
REQ-037 sel_rdy, sel_data 0,16,1, sel_cmp; coin 20 -> ticket_go stn=1, then change_go amt=4.
REQ-038 Fee 23; coins 10,13 -> ticket_go stn=2, no change_go, credit 0.
REQ-039 Fee 44; coin 20 then cancel with coin 30 same cycle -> no ticket_go, change_go amt=50.
REQ-040 Coin in IDLE -> coin_rej pulse, credit stays 0; fee 0 selection -> err pulse, busy low.
REQ-041 VEND_TIMEOUT_EN, TIMEOUT_CYCLES=8, fee 30, coin 10, no further input -> change_go amt=10 after timeout.
REQ-042 rst asserted in COLLECT with credit 15 -> IDLE, credit 0, no change_go.

Source files
------------

// File: rtl/vend_controller_if.sv
// Handshake bundle for the ticket vending controller: selection bus from the
// button scanner, coin mechanism strobes, cancel, ticket/change strobes, status.
//   master : drives selection, coin and cancel; observes ticket/change/status
//   slave  : the controller itself
interface vend_controller_if;
   logic       sel_rdy;
   logic [7:0] sel_data;
   logic       sel_cmp;
   logic       coin_valid;
   logic [7:0] coin_val;
   logic       cancel;
   logic       ticket_go;
   logic [7:0] ticket_stn;
   logic       change_go;
   logic [7:0] change_amt;
   logic [7:0] credit;
   logic       busy;
   logic       err;
   logic       coin_rej;

   modport master (
      output sel_rdy, sel_data, sel_cmp, coin_valid, coin_val, cancel,
      input  ticket_go, ticket_stn, change_go, change_amt,
      input  credit, busy, err, coin_rej
   );

   modport slave (
      input  sel_rdy, sel_data, sel_cmp, coin_valid, coin_val, cancel,
      output ticket_go, ticket_stn, change_go, change_amt,
      output credit, busy, err, coin_rej
   );
endinterface

// File: rtl/vend_controller.sv
// Ticket vending controller: reads fee and station code from the selection
// bus, collects coins, prints the ticket and returns change or refunds.
// Ports: clk, rst (async, active-high), bus (vend_controller_if.slave).
// Optional macro VEND_TIMEOUT_EN: refund after TIMEOUT_CYCLES idle cycles
// in COLLECT; without it COLLECT only exits via payment or cancel.
module vend_controller #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic              clk,
   input logic              rst,
   vend_controller_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, FEE, STN, SYNC, COLLECT, DISPENSE, CHANGE, REFUND
   } state_t;

   state_t     state;
   logic [7:0] fee;
   logic [7:0] stn;
   logic [7:0] credit_q;
   logic       ticket_go_q;
   logic [7:0] ticket_stn_q;
   logic       change_go_q;
   logic [7:0] change_amt_q;
   logic       busy_q;
   logic       err_q;
   logic       coin_rej_q;

   logic [8:0] sum;
   logic [7:0] next_credit;
   logic       paid;
   logic       tmo_hit;

   // Credit as it would stand after this cycle's coin, saturating at 255.
   always_comb begin
      sum         = {1'b0, credit_q} + {1'b0, bus.coin_val};
      next_credit = credit_q;
      if (bus.coin_valid)
         next_credit = sum[8] ? 8'hFF : sum[7:0];
      paid = (next_credit >= fee);
   end

`ifdef VEND_TIMEOUT_EN
   localparam int unsigned TW =
      (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TW-1:0] tmo_cnt;
   assign tmo_hit = (32'(tmo_cnt) == TIMEOUT_CYCLES - 1);
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         fee          <= 8'd0;
         stn          <= 8'd0;
         credit_q     <= 8'd0;
         ticket_go_q  <= 1'b0;
         ticket_stn_q <= 8'd0;
         change_go_q  <= 1'b0;
         change_amt_q <= 8'd0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         coin_rej_q   <= 1'b0;
`ifdef VEND_TIMEOUT_EN
         tmo_cnt      <= '0;
`endif
      end else begin
         ticket_go_q <= 1'b0;
         change_go_q <= 1'b0;
         err_q       <= 1'b0;
         coin_rej_q  <= bus.coin_valid && (state != COLLECT);
         unique case (state)
            IDLE: begin
               if (bus.sel_rdy) begin
                  state  <= FEE;
                  busy_q <= 1'b1;
               end
            end
            FEE: begin
               fee   <= bus.sel_data;
               state <= STN;
            end
            STN: begin
               stn   <= bus.sel_data;
               state <= SYNC;
            end
            SYNC: begin
               if (bus.sel_cmp) begin
                  if (fee == 8'd0) begin
                     err_q  <= 1'b1;
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     state <= COLLECT;
`ifdef VEND_TIMEOUT_EN
                     tmo_cnt <= '0;
`endif
                  end
               end else if (!bus.sel_rdy) begin
                  // Scanner dropped the selection before completing it.
                  err_q  <= 1'b1;
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            COLLECT: begin
               credit_q <= next_credit;
`ifdef VEND_TIMEOUT_EN
               if (bus.coin_valid)
                  tmo_cnt <= '0;
               else
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               // Cancel beats payment; a same-cycle coin is refunded too.
               if (bus.cancel || (!bus.coin_valid && tmo_hit)) begin
                  state    <= REFUND;
                  credit_q <= 8'd0;
                  if (next_credit != 8'd0) begin
                     change_go_q  <= 1'b1;
                     change_amt_q <= next_credit;
                  end
               end else if (paid) begin
                  state        <= DISPENSE;
                  ticket_go_q  <= 1'b1;
                  ticket_stn_q <= stn;
               end
            end
            DISPENSE: begin
               credit_q <= 8'd0;
               if (credit_q > fee) begin
                  state        <= CHANGE;
                  change_go_q  <= 1'b1;
                  change_amt_q <= credit_q - fee;
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            CHANGE: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            REFUND: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ticket_go  = ticket_go_q;
   assign bus.ticket_stn = ticket_stn_q;
   assign bus.change_go  = change_go_q;
   assign bus.change_amt = change_amt_q;
   assign bus.credit     = credit_q;
   assign bus.busy       = busy_q;
   assign bus.err        = err_q;
   assign bus.coin_rej   = coin_rej_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed testbench for vend_controller: purchase with change, exact fee,
// cancel with same-cycle coin, rejects/errors, saturation, timeout, reset.
module tb_vend_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;

   vend_controller_if bus ();

   vend_controller #(.TIMEOUT_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.sel_rdy    = 1'b0;
      bus.sel_data   = 8'd0;
      bus.sel_cmp    = 1'b0;
      bus.coin_valid = 1'b0;
      bus.coin_val   = 8'd0;
      bus.cancel     = 1'b0;
   endtask

   task automatic select(input logic [7:0] f, input logic [7:0] s);
      bus.sel_rdy = 1'b1; bus.sel_data = 8'd0; tick();
      bus.sel_rdy = 1'b0; bus.sel_data = f; tick();
      bus.sel_data = s; tick();
      bus.sel_cmp = 1'b1; tick();
      bus.sel_cmp = 1'b0; bus.sel_data = 8'd0;
   endtask

   task automatic coin(input logic [7:0] v);
      bus.coin_valid = 1'b1; bus.coin_val = v; tick();
      bus.coin_valid = 1'b0; bus.coin_val = 8'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      #1;
      total++;
      if ({bus.busy, bus.credit, bus.ticket_go, bus.change_go, bus.err} !== 12'd0) begin
         bad++;
         $display("FAIL reset_outputs got busy=%b credit=%0d tg=%b cg=%b err=%b exp all 0",
                  bus.busy, bus.credit, bus.ticket_go, bus.change_go, bus.err);
      end
      tick(); tick();
      rst = 1'b0;
      tick();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL reset_idle got busy=%b exp 0", bus.busy);
      end
   endtask

   task automatic test_change();
      select(8'd16, 8'd1);
      total++;
      if (bus.busy !== 1'b1) begin
         bad++; $display("FAIL chg_busy got %b exp 1", bus.busy);
      end
      coin(8'd20);
      total++;
      if (bus.ticket_go !== 1'b1 || bus.ticket_stn !== 8'd1 || bus.change_go !== 1'b0) begin
         bad++;
         $display("FAIL chg_ticket got tg=%b stn=%0d cg=%b exp tg=1 stn=1 cg=0",
                  bus.ticket_go, bus.ticket_stn, bus.change_go);
      end
      tick();
      total++;
      if (bus.change_go !== 1'b1 || bus.change_amt !== 8'd4 || bus.ticket_go !== 1'b0) begin
         bad++;
         $display("FAIL chg_amount got cg=%b amt=%0d tg=%b exp cg=1 amt=4 tg=0",
                  bus.change_go, bus.change_amt, bus.ticket_go);
      end
      tick();
      total++;
      if (bus.change_go !== 1'b0 || bus.change_amt !== 8'd4 || bus.busy !== 1'b0 ||
          bus.credit !== 8'd0) begin
         bad++;
         $display("FAIL chg_done got cg=%b amt=%0d busy=%b credit=%0d exp 0 4 0 0",
                  bus.change_go, bus.change_amt, bus.busy, bus.credit);
      end
   endtask

   task automatic test_exact();
      logic seen_chg;
      seen_chg = 1'b0;
      select(8'd23, 8'd2);
      coin(8'd10);
      total++;
      if (bus.credit !== 8'd10 || bus.ticket_go !== 1'b0) begin
         bad++;
         $display("FAIL exact_partial got credit=%0d tg=%b exp 10 0", bus.credit, bus.ticket_go);
      end
      coin(8'd13);
      seen_chg = seen_chg | bus.change_go;
      total++;
      if (bus.ticket_go !== 1'b1 || bus.ticket_stn !== 8'd2) begin
         bad++;
         $display("FAIL exact_ticket got tg=%b stn=%0d exp 1 2", bus.ticket_go, bus.ticket_stn);
      end
      tick();
      seen_chg = seen_chg | bus.change_go;
      tick();
      seen_chg = seen_chg | bus.change_go;
      total++;
      if (seen_chg !== 1'b0 || bus.credit !== 8'd0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL exact_nochange got cg_seen=%b credit=%0d busy=%b exp 0 0 0",
                  seen_chg, bus.credit, bus.busy);
      end
   endtask

   task automatic test_cancel();
      select(8'd44, 8'd3);
      coin(8'd20);
      bus.cancel = 1'b1; bus.coin_valid = 1'b1; bus.coin_val = 8'd30;
      tick();
      idle_inputs();
      total++;
      if (bus.change_go !== 1'b1 || bus.change_amt !== 8'd50 || bus.ticket_go !== 1'b0 ||
          bus.credit !== 8'd0) begin
         bad++;
         $display("FAIL cancel_refund got cg=%b amt=%0d tg=%b credit=%0d exp 1 50 0 0",
                  bus.change_go, bus.change_amt, bus.ticket_go, bus.credit);
      end
      tick();
      total++;
      if (bus.ticket_go !== 1'b0 || bus.change_go !== 1'b0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL cancel_after got tg=%b cg=%b busy=%b exp 0 0 0",
                  bus.ticket_go, bus.change_go, bus.busy);
      end
   endtask

   task automatic test_reject_err();
      coin(8'd5);
      total++;
      if (bus.coin_rej !== 1'b1 || bus.credit !== 8'd0) begin
         bad++;
         $display("FAIL coin_rej got rej=%b credit=%0d exp 1 0", bus.coin_rej, bus.credit);
      end
      tick();
      total++;
      if (bus.coin_rej !== 1'b0) begin
         bad++; $display("FAIL coin_rej_pulse got %b exp 0", bus.coin_rej);
      end
      bus.cancel = 1'b1;
      select(8'd0, 8'd3);
      bus.cancel = 1'b0;
      total++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL fee0_err got err=%b busy=%b exp 1 0", bus.err, bus.busy);
      end
      tick();
      total++;
      if (bus.err !== 1'b0) begin
         bad++; $display("FAIL fee0_pulse got %b exp 0", bus.err);
      end
      bus.sel_rdy = 1'b1; tick();
      bus.sel_rdy = 1'b0; bus.sel_data = 8'd5; tick();
      bus.sel_data = 8'd7; tick();
      bus.sel_data = 8'd0; tick();
      total++;
      if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL sync_abort got err=%b busy=%b exp 1 0", bus.err, bus.busy);
      end
      tick();
   endtask

   task automatic test_saturate();
      select(8'd255, 8'd6);
      coin(8'd200);
      coin(8'd100);
      total++;
      if (bus.credit !== 8'd255 || bus.ticket_go !== 1'b1 || bus.ticket_stn !== 8'd6) begin
         bad++;
         $display("FAIL saturate got credit=%0d tg=%b stn=%0d exp 255 1 6",
                  bus.credit, bus.ticket_go, bus.ticket_stn);
      end
      tick();
      total++;
      if (bus.change_go !== 1'b0 || bus.credit !== 8'd0 || bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL saturate_end got cg=%b credit=%0d busy=%b exp 0 0 0",
                  bus.change_go, bus.credit, bus.busy);
      end
   endtask

   task automatic test_timeout();
      int n;
      select(8'd30, 8'd4);
      coin(8'd10);
`ifdef VEND_TIMEOUT_EN
      n = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.change_go === 1'b1) begin
            n = i;
            break;
         end
      end
      total++;
      if (n != 8 || bus.change_amt !== 8'd10) begin
         bad++;
         $display("FAIL timeout_refund got cycle=%0d amt=%0d exp 8 10", n, bus.change_amt);
      end
      tick();
`else
      n = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.busy !== 1'b1 || bus.change_go !== 1'b0) n++;
      end
      total++;
      if (n != 0) begin
         bad++; $display("FAIL no_timeout got early_exits=%0d exp 0", n);
      end
      bus.cancel = 1'b1; tick();
      bus.cancel = 1'b0;
      total++;
      if (bus.change_go !== 1'b1 || bus.change_amt !== 8'd10) begin
         bad++;
         $display("FAIL no_timeout_cancel got cg=%b amt=%0d exp 1 10",
                  bus.change_go, bus.change_amt);
      end
      tick();
`endif
      total++;
      if (bus.busy !== 1'b0) begin
         bad++; $display("FAIL timeout_idle got busy=%b exp 0", bus.busy);
      end
   endtask

   task automatic test_mid_reset();
      logic seen_chg;
      select(8'd40, 8'd9);
      coin(8'd15);
      total++;
      if (bus.credit !== 8'd15) begin
         bad++; $display("FAIL midrst_credit got %0d exp 15", bus.credit);
      end
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (bus.credit !== 8'd0 || bus.busy !== 1'b0 || bus.change_go !== 1'b0) begin
         bad++;
         $display("FAIL midrst_async got credit=%0d busy=%b cg=%b exp 0 0 0",
                  bus.credit, bus.busy, bus.change_go);
      end
      tick();
      rst = 1'b0;
      seen_chg = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         seen_chg = seen_chg | bus.change_go;
      end
      total++;
      if (seen_chg !== 1'b0 || bus.busy !== 1'b0 || bus.credit !== 8'd0) begin
         bad++;
         $display("FAIL midrst_after got cg_seen=%b busy=%b credit=%0d exp 0 0 0",
                  seen_chg, bus.busy, bus.credit);
      end
   endtask

   initial begin
      test_reset();
      test_change();
      test_exact();
      test_cancel();
      test_reject_err();
      test_saturate();
      test_timeout();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
